// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency fetch lookup, training from EX, mispredict detection and saturating statistics.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] IF_PC,
  output logic              Pred_Taken,
  output logic [ADDR_W-1:0] Pred_NextPC,
  input  logic              EX_Update,
  input  logic [ADDR_W-1:0] EX_PC,
  input  logic              EX_Taken,
  input  logic [ADDR_W-1:0] EX_Target,
  input  logic              EX_PredTaken,
  input  logic [ADDR_W-1:0] EX_PredNextPC,
  output logic              Mispredict,
  output logic [ADDR_W-1:0] Redirect_PC,
  output logic [CNT_W-1:0]  Branch_Count,
  output logic [CNT_W-1:0]  Mispredict_Count
);
  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [ADDR_W-1:0] r_target [DEPTH];
  logic [1:0]        r_ctr    [DEPTH];
  logic [CNT_W-1:0]  r_branch_cnt;
  logic [CNT_W-1:0]  r_mispred_cnt;

  logic [INDEX_W-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]   w_if_tag, w_ex_tag;
  logic               w_if_hit, w_ex_hit;
  logic               w_unused;

  assign w_if_idx = IF_PC[INDEX_W+1:2];
  assign w_if_tag = IF_PC[ADDR_W-1:INDEX_W+2];
  assign w_ex_idx = EX_PC[INDEX_W+1:2];
  assign w_ex_tag = EX_PC[ADDR_W-1:INDEX_W+2];
  assign w_unused = ^{IF_PC[1:0], EX_PC[1:0]};

  // Lookup reads pre-update contents; no bypass from a same-cycle write.
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign Pred_Taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign Pred_NextPC = Pred_Taken ? r_target[w_if_idx] : IF_PC + ADDR_W'(4);

  assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign Mispredict  = EX_Update && ((EX_Taken != EX_PredTaken) ||
                                     (EX_Taken && (EX_Target != EX_PredNextPC)));
  assign Redirect_PC = EX_Taken ? EX_Target : EX_PC + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (EX_Update) begin
      if (w_ex_hit) begin
        if (EX_Taken) begin
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          r_target[w_ex_idx] <= EX_Target;
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (EX_Taken) begin
        // Taken miss allocates (or evicts an alias) as weakly taken.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= EX_Target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (EX_Update && (r_branch_cnt != '1))  r_branch_cnt  <= r_branch_cnt + 1'b1;
      if (Mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign Branch_Count     = r_branch_cnt;
  assign Mispredict_Count = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven directed bench for branch_predictor (CNT_W=4 so saturation is reachable).
module tb_branch_predictor;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] IF_PC, EX_PC, EX_Target, EX_PredNextPC;
  logic          EX_Update, EX_Taken, EX_PredTaken;
  logic          Pred_Taken, Mispredict;
  logic [AW-1:0] Pred_NextPC, Redirect_PC;
  logic [CW-1:0] Branch_Count, Mispredict_Count;

  branch_predictor #(.ADDR_W(AW), .INDEX_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .IF_PC(IF_PC), .Pred_Taken(Pred_Taken), .Pred_NextPC(Pred_NextPC),
    .EX_Update(EX_Update), .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_PredTaken(EX_PredTaken), .EX_PredNextPC(EX_PredNextPC), .Mispredict(Mispredict),
    .Redirect_PC(Redirect_PC), .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        upd;
    logic [31:0] ex_pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] pnx;
    logic        e_pt;
    logic [31:0] e_pn;
    logic        e_mp;
    logic [31:0] e_rd;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] if_pc, input logic upd, input logic [31:0] ex_pc,
                     input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] pnx,
                     input logic e_pt, input logic [31:0] e_pn, input logic e_mp,
                     input logic [31:0] e_rd, input logic [31:0] e_bc, input logic [31:0] e_mc);
    vec_t v;
    v.if_pc = if_pc; v.upd = upd; v.ex_pc = ex_pc; v.tk = tk; v.tgt = tgt; v.ptk = ptk;
    v.pnx = pnx; v.e_pt = e_pt; v.e_pn = e_pn; v.e_mp = e_mp; v.e_rd = e_rd;
    v.e_bc = e_bc; v.e_mc = e_mc;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [31:0] if_pc, input logic upd, input logic [31:0] ex_pc,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] pnx);
    IF_PC = if_pc; EX_Update = upd; EX_PC = ex_pc; EX_Taken = tk;
    EX_Target = tgt; EX_PredTaken = ptk; EX_PredNextPC = pnx;
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] bc, input logic [31:0] mc);
    chk({nm, ".bcnt"}, {28'd0, Branch_Count}, bc);
    chk({nm, ".mcnt"}, {28'd0, Mispredict_Count}, mc);
  endtask

  initial begin
    // if_pc upd ex_pc tk tgt ptk pnx | pt pn mp rd bc mc
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 0, 32'h00400014, 0, 32'h4, 0, 0);
    add(32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400040, 0, 0);
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 1, 32'h00400040, 0, 32'h4, 1, 1);
    add(32'h00400050, 0, 0, 0, 0, 0, 0,                                 0, 32'h00400054, 0, 32'h4, 1, 1);
    add(32'h00400010, 1, 32'h00400010, 0, 0, 1, 32'h00400040,           1, 32'h00400040, 1, 32'h00400014, 1, 1);
    add(32'h00400010, 1, 32'h00400010, 0, 0, 0, 32'h00400014,           0, 32'h00400014, 0, 32'h00400014, 2, 2);
    add(32'h00400010, 1, 32'h00400010, 0, 0, 0, 32'h00400014,           0, 32'h00400014, 0, 32'h00400014, 3, 2);
    add(32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400040, 4, 2);
    add(32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400040, 5, 3);
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 1, 32'h00400040, 0, 32'h4, 6, 4);
    add(32'h00400010, 1, 32'h00400010, 1, 32'h00400080, 1, 32'h00400040, 1, 32'h00400040, 1, 32'h00400080, 6, 4);
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 1, 32'h00400080, 0, 32'h4, 7, 5);
    add(32'h00400010, 1, 32'h00400010, 1, 32'h00400080, 1, 32'h00400080, 1, 32'h00400080, 0, 32'h00400080, 7, 5);
    add(32'h00400010, 1, 32'h00400010, 0, 0, 1, 32'h00400080,           1, 32'h00400080, 1, 32'h00400014, 8, 5);
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 1, 32'h00400080, 0, 32'h4, 9, 6);
    add(32'h00400050, 1, 32'h00400050, 1, 32'h00400100, 0, 32'h00400054, 0, 32'h00400054, 1, 32'h00400100, 9, 6);
    add(32'h00400050, 0, 0, 0, 0, 0, 0,                                 1, 32'h00400100, 0, 32'h4, 10, 7);
    add(32'h00400010, 0, 0, 0, 0, 0, 0,                                 0, 32'h00400014, 0, 32'h4, 10, 7);
    add(32'h00400020, 1, 32'h00400020, 0, 0, 0, 32'h00400024,           0, 32'h00400024, 0, 32'h00400024, 10, 7);
    add(32'h00400020, 0, 0, 0, 0, 0, 0,                                 0, 32'h00400024, 0, 32'h4, 11, 7);
    add(32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 0, 1, 32'h00000000,           0, 32'h00000000, 0, 32'h0, 11, 7);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[k]) begin
      drive(vq[k].if_pc, vq[k].upd, vq[k].ex_pc, vq[k].tk, vq[k].tgt, vq[k].ptk, vq[k].pnx);
      #1;
      chk($sformatf("v%0d.pred_taken", k), {31'd0, Pred_Taken}, {31'd0, vq[k].e_pt});
      chk($sformatf("v%0d.pred_next", k), Pred_NextPC, vq[k].e_pn);
      chk($sformatf("v%0d.mispredict", k), {31'd0, Mispredict}, {31'd0, vq[k].e_mp});
      chk($sformatf("v%0d.redirect", k), Redirect_PC, vq[k].e_rd);
      chk_cnt($sformatf("v%0d", k), vq[k].e_bc, vq[k].e_mc);
      @(negedge clk);
    end

    // Ten mispredicting updates push both 4-bit counters into saturation.
    for (int i = 0; i < 10; i++) begin
      drive(32'h00400200, 1, 32'h00400200, 1, 32'h00400300, 0, 32'h00400204);
      @(negedge clk);
      if (i == 3) chk_cnt("sat_mid", 15, 11);
    end
    drive(32'h00400200, 0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt("sat_end", 15, 15);
    chk("sat_entry.pred_taken", {31'd0, Pred_Taken}, 32'd1);
    chk("sat_entry.pred_next", Pred_NextPC, 32'h00400300);
    @(negedge clk);

    // Update coincident with reset: combinational outputs still live, state not written.
    rst = 1'b1;
    drive(32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014);
    #1;
    chk("rst_upd.mispredict", {31'd0, Mispredict}, 32'd1);
    chk("rst_upd.redirect", Redirect_PC, 32'h00400040);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h00400010, 0, 0, 0, 0, 0, 0);
    #1;
    chk_cnt("post_rst", 0, 0);
    chk("post_rst.pred_taken", {31'd0, Pred_Taken}, 32'd0);
    chk("post_rst.pred_next", Pred_NextPC, 32'h00400014);
    IF_PC = 32'h00400200;
    #1;
    chk("post_rst.cleared", {31'd0, Pred_Taken}, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the five-stage MIPS pipeline. It predicts the fetch-stage next PC in the same cycle as the instruction-memory read, which removes the taken-branch penalty the pipeline currently pays by resolving branches in EX. It is trained by the resolved outcome from EX, raises a mispredict/redirect request, and keeps registered branch and mispredict statistics.

## Interface
- ADDR_W, 32, PC width in bits.
- INDEX_W, 4, index bits; the buffer holds 2^INDEX_W entries and is direct-mapped.
- TAG_W, ADDR_W-INDEX_W-2, tag width; tag = PC[ADDR_W-1:INDEX_W+2].
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- IF_PC  in  ADDR_W  fetch PC; index = IF_PC[INDEX_W+1:2].
- Pred_Taken  out  1  combinational; high when the entry hits and counter[1]=1.
- Pred_NextPC  out  ADDR_W  combinational; stored target if Pred_Taken, else IF_PC+4.
- EX_Update  in  1  a real (non-bubble) conditional branch is resolved in EX this cycle.
- EX_PC  in  ADDR_W  PC of the resolving branch.
- EX_Taken  in  1  actual branch outcome.
- EX_Target  in  ADDR_W  actual branch target.
- EX_PredTaken  in  1  Pred_Taken value carried down the pipeline with this branch.
- EX_PredNextPC  in  ADDR_W  Pred_NextPC value carried down with this branch.
- Mispredict  out  1  combinational flush request for IF/ID and ID/EX.
- Redirect_PC  out  ADDR_W  combinational; EX_Taken ? EX_Target : EX_PC+4.
- Branch_Count  out  CNT_W  registered count of EX_Update cycles.
- Mispredict_Count  out  CNT_W  registered count of Mispredict cycles.

## Operation
- Entry fields: valid (1), tag (TAG_W), target (ADDR_W), ctr (2). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational): hit = valid[idx] & (tag[idx] == IF_PC tag). Pred_Taken = hit & ctr[idx][1].
- Mispredict = EX_Update & ((EX_Taken != EX_PredTaken) | (EX_Taken & (EX_Target != EX_PredNextPC))). It is forced to 0 whenever EX_Update=0.
- Update when EX_Update=1 and rst=0 (EX_PC index e, tag t):
  - Hit on e with tag t: ctr saturating +1 if taken, saturating -1 if not taken; target <= EX_Target when taken.
  - Miss and taken: allocate or overwrite e with valid=1, tag=t, target=EX_Target, ctr=10.
  - Miss and not taken: no change.
- Statistics: Branch_Count +1 on EX_Update; Mispredict_Count +1 on Mispredict. Both saturate at all-ones and do not wrap.
- PC arithmetic (+4) is modulo 2^ADDR_W. PC[1:0] is ignored for index and tag.

## Timing
- Lookup has zero latency: Pred_* is valid in the same cycle as IF_PC.
- Update latency is 1 cycle: an entry written at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Mispredict and Redirect_PC are same-cycle with EX_Update. The PC mux gives Mispredict priority over Pred_NextPC.
- Reset state (one edge with rst=1): all valid=0, all ctr=01, all target=0, Branch_Count=0, Mispredict_Count=0.
- An EX_Update in a cycle with rst=1 is ignored and not counted.
- Outputs after reset: Pred_Taken=0, Pred_NextPC=IF_PC+4.
- Mispredict and Redirect_PC are purely combinational on the EX inputs even during reset.
- Back-to-back updates to the same entry on consecutive cycles each apply in order. A saturating counter at 11 stays at 11 when taken; at 00 it stays at 00 when not taken.

## Test plan
- Reset, then IF_PC=0x00400010 -> Pred_Taken=0, Pred_NextPC=0x00400014; both counters read 0.
- EX_Update with EX_PC=0x00400010, EX_Taken=1, EX_Target=0x00400040, EX_PredTaken=0 -> Mispredict=1, Redirect_PC=0x00400040. Next cycle, IF_PC=0x00400010 -> Pred_Taken=1, Pred_NextPC=0x00400040, Mispredict_Count=1.
- Aliasing: after the previous step, IF_PC=0x00400050 (same index 4, different tag) -> Pred_Taken=0, Pred_NextPC=0x00400054.
- Counter training: three not-taken updates on the trained entry (10->01->00->00) -> Pred_Taken=0 after the first. Two taken updates then give 01->10, and Pred_Taken=1 again.
- Same-cycle lookup and allocate on index 4 -> lookup shows the old value; the following cycle shows the new value. EX_Update asserted together with rst=1 -> no entry written, Branch_Count stays 0.
- Target change on a hit: entry predicts 0x00400040, EX_Taken=1, EX_Target=0x00400080 -> Mispredict=1 and the target is updated. Force Branch_Count to all-ones with CNT_W=4 -> the count holds at 0xF.
